// File: rtl/sal_pkg.sv
// Shared command and bank-state encodings for the SAL bank controller.
package sal_pkg;

  typedef enum logic [1:0] {
    CMD_ACT = 2'd0,
    CMD_RD  = 2'd1,
    CMD_WR  = 2'd2,
    CMD_PRE = 2'd3
  } cmd_t;

  typedef enum logic {
    ST_CLOSED = 1'b0,
    ST_OPEN   = 1'b1
  } state_t;

endpackage

// File: rtl/sal_timing_cntr.sv
// Saturating down counter for one DRAM timing constraint; constraint met when cnt is zero.
// Load takes effect next cycle; no flow control of its own.
module sal_timing_cntr #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - WIDTH'(1);
    end
  end

endmodule

// File: rtl/sal_bank_ctrl.sv
// Single-bank open-page DRAM controller: ACT/RD/WR/PRE sequencing under tRCD/tRP/tRAS/tRTP/tWTP/tCCD.
// Commands offered combinationally once timing is met; a stalled offer is held stable until cmd_ready_i.
module sal_bank_ctrl
  import sal_pkg::*;
#(
  parameter int CNTR_WIDTH = 4,
  parameter int ROW_WIDTH  = 14,
  parameter int T_RCD      = 4,
  parameter int T_RP       = 4,
  parameter int T_RAS      = 12,
  parameter int T_RTP      = 3,
  parameter int T_WTP      = 8,
  parameter int T_CCD      = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_wr_i,
  input  logic [ROW_WIDTH-1:0] req_row_i,
  input  logic                 ref_req_i,
  output logic                 ref_gnt_o,
  output logic                 cmd_valid_o,
  input  logic                 cmd_ready_i,
  output logic [1:0]           cmd_o,
  output logic [ROW_WIDTH-1:0] cmd_row_o
);

  localparam logic [CNTR_WIDTH-1:0] RCD_LD = CNTR_WIDTH'(T_RCD - 1);
  localparam logic [CNTR_WIDTH-1:0] RP_LD  = CNTR_WIDTH'(T_RP - 1);
  localparam logic [CNTR_WIDTH-1:0] RAS_LD = CNTR_WIDTH'(T_RAS - 1);
  localparam logic [CNTR_WIDTH-1:0] RTP_LD = CNTR_WIDTH'(T_RTP - 1);
  localparam logic [CNTR_WIDTH-1:0] WTP_LD = CNTR_WIDTH'(T_WTP - 1);
  localparam logic [CNTR_WIDTH-1:0] CCD_LD = CNTR_WIDTH'(T_CCD - 1);

  state_t                 state;
  logic [ROW_WIDTH-1:0]   open_row;
  logic                   held;
  cmd_t                   held_cmd;
  logic [ROW_WIDTH-1:0]   held_row;

  logic [CNTR_WIDTH-1:0]  rcd_cnt, rp_cnt, ras_cnt, wtp_cnt, ccd_cnt;
  logic [CNTR_WIDTH-1:0]  wtp_dec, col_ld, wtp_ld;

  logic                   offer;
  cmd_t                   offer_cmd;
  logic [ROW_WIDTH-1:0]   offer_row;
  logic                   issue, act_issue, pre_issue, col_issue;

  // Refresh outranks requests; a row miss closes the bank before reopening.
  always_comb begin
    offer     = 1'b0;
    offer_cmd = CMD_ACT;
    offer_row = open_row;
    if (held) begin
      offer     = 1'b1;
      offer_cmd = held_cmd;
      offer_row = held_row;
    end else if (state == ST_CLOSED) begin
      if (req_valid_i && !ref_req_i && rp_cnt == '0) begin
        offer     = 1'b1;
        offer_row = req_row_i;
      end
    end else if (ref_req_i || (req_valid_i && req_row_i != open_row)) begin
      if (ras_cnt == '0 && wtp_cnt == '0) begin
        offer     = 1'b1;
        offer_cmd = CMD_PRE;
      end
    end else if (req_valid_i && rcd_cnt == '0 && ccd_cnt == '0) begin
      offer     = 1'b1;
      offer_cmd = req_wr_i ? CMD_WR : CMD_RD;
    end
  end

  assign cmd_valid_o = offer && !rst;
  assign cmd_o       = offer_cmd;
  assign cmd_row_o   = offer_row;
  assign issue       = cmd_valid_o && cmd_ready_i;
  assign act_issue   = issue && (offer_cmd == CMD_ACT);
  assign pre_issue   = issue && (offer_cmd == CMD_PRE);
  assign col_issue   = issue && (offer_cmd == CMD_RD || offer_cmd == CMD_WR);
  assign req_ready_o = col_issue;
  assign ref_gnt_o   = (state == ST_CLOSED) && (rp_cnt == '0);

  // Overlapping column commands must not shorten an earlier, longer PRE holdoff.
  assign wtp_dec = (wtp_cnt != '0) ? wtp_cnt - CNTR_WIDTH'(1) : '0;
  assign col_ld  = (offer_cmd == CMD_WR) ? WTP_LD : RTP_LD;
  assign wtp_ld  = (wtp_dec > col_ld) ? wtp_dec : col_ld;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_CLOSED;
      open_row <= '0;
      held     <= 1'b0;
      held_cmd <= CMD_ACT;
      held_row <= '0;
    end else begin
      held <= cmd_valid_o && !cmd_ready_i;
      if (cmd_valid_o && !cmd_ready_i) begin
        held_cmd <= offer_cmd;
        held_row <= offer_row;
      end
      if (act_issue) begin
        state    <= ST_OPEN;
        open_row <= offer_row;
      end else if (pre_issue) begin
        state <= ST_CLOSED;
      end
    end
  end

  sal_timing_cntr #(.WIDTH(CNTR_WIDTH)) u_rcd (
    .clk(clk), .rst(rst), .load(act_issue), .load_val(RCD_LD), .cnt(rcd_cnt));
  sal_timing_cntr #(.WIDTH(CNTR_WIDTH)) u_rp (
    .clk(clk), .rst(rst), .load(pre_issue), .load_val(RP_LD), .cnt(rp_cnt));
  sal_timing_cntr #(.WIDTH(CNTR_WIDTH)) u_ras (
    .clk(clk), .rst(rst), .load(act_issue), .load_val(RAS_LD), .cnt(ras_cnt));
  sal_timing_cntr #(.WIDTH(CNTR_WIDTH)) u_wtp (
    .clk(clk), .rst(rst), .load(col_issue), .load_val(wtp_ld), .cnt(wtp_cnt));
  sal_timing_cntr #(.WIDTH(CNTR_WIDTH)) u_ccd (
    .clk(clk), .rst(rst), .load(col_issue), .load_val(CCD_LD), .cnt(ccd_cnt));

endmodule

// File: tb/tb_sal_bank_ctrl.sv
// Directed scenarios plus randomized traffic against a cycle-timestamp reference model of the bank.
module tb_sal_bank_ctrl;
  import sal_pkg::*;

  localparam int RW    = 14;
  localparam int T_RCD = 4;
  localparam int T_RP  = 4;
  localparam int T_RAS = 12;
  localparam int T_RTP = 3;
  localparam int T_WTP = 8;
  localparam int T_CCD = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, req_valid_i, req_ready_o, req_wr_i, ref_req_i, ref_gnt_o;
  logic          cmd_valid_o, cmd_ready_i;
  logic [1:0]    cmd_o;
  logic [RW-1:0] req_row_i, cmd_row_o;

  sal_bank_ctrl #(
    .CNTR_WIDTH(4), .ROW_WIDTH(RW), .T_RCD(T_RCD), .T_RP(T_RP), .T_RAS(T_RAS),
    .T_RTP(T_RTP), .T_WTP(T_WTP), .T_CCD(T_CCD)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_wr_i(req_wr_i),
    .req_row_i(req_row_i), .ref_req_i(ref_req_i), .ref_gnt_o(ref_gnt_o),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
    .cmd_o(cmd_o), .cmd_row_o(cmd_row_o)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: bank open/closed, open row, and the cycle of the last command of each kind.
  bit            m_open;
  logic [RW-1:0] m_row;
  int            t_act, t_pre, t_col, t_pre_ok;
  bit            m_pend;
  logic [1:0]    m_pcmd;
  logic [RW-1:0] m_prow;
  bit            consumed;

  // Observed issue log taken from the DUT pins.
  int            o_act, o_pre, o_rd, o_wr, o_gnt_rise;
  logic [RW-1:0] o_act_row;
  logic          prev_gnt;

  logic [RW-1:0] rows [3] = '{14'd5, 14'd9, 14'd3};

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_open   = 1'b0;
    m_row    = '0;
    t_act    = -1000;
    t_pre    = -1000;
    t_col    = -1000;
    t_pre_ok = -1000;
    m_pend   = 1'b0;
  endtask

  // One clock cycle: inputs already driven just after the edge; check mid-cycle, then advance.
  task automatic tick();
    bit            ev, eg, erdy;
    logic [1:0]    ec;
    logic [RW-1:0] er;
    #4;
    ev = 1'b0; ec = CMD_ACT; er = m_row;
    if (m_pend) begin
      ev = 1'b1; ec = m_pcmd; er = m_prow;
    end else if (!m_open) begin
      if (req_valid_i && !ref_req_i && cyc >= t_pre + T_RP) begin
        ev = 1'b1; ec = CMD_ACT; er = req_row_i;
      end
    end else if (ref_req_i || (req_valid_i && req_row_i != m_row)) begin
      if (cyc >= t_act + T_RAS && cyc >= t_pre_ok) begin
        ev = 1'b1; ec = CMD_PRE; er = m_row;
      end
    end else if (req_valid_i && cyc >= t_act + T_RCD && cyc >= t_col + T_CCD) begin
      ev = 1'b1; ec = req_wr_i ? CMD_WR : CMD_RD; er = m_row;
    end
    if (rst) ev = 1'b0;
    eg   = !m_open && cyc >= t_pre + T_RP;
    erdy = ev && cmd_ready_i && (ec == CMD_RD || ec == CMD_WR);

    chk("cmd_valid", cmd_valid_o, ev);
    chk("req_ready", req_ready_o, erdy);
    chk("ref_gnt", ref_gnt_o, eg);
    if (ev) begin
      chk("cmd", cmd_o, ec);
      chk("cmd_row", cmd_row_o, er);
    end

    if (!rst && cmd_valid_o && cmd_ready_i) begin
      case (cmd_o)
        CMD_ACT: begin o_act = cyc; o_act_row = cmd_row_o; end
        CMD_PRE: o_pre = cyc;
        CMD_RD:  o_rd  = cyc;
        default: o_wr  = cyc;
      endcase
    end
    if (ref_gnt_o && !prev_gnt) o_gnt_rise = cyc;
    prev_gnt = ref_gnt_o;
    consumed = erdy;

    if (rst) begin
      model_reset();
    end else if (ev && cmd_ready_i) begin
      m_pend = 1'b0;
      case (ec)
        CMD_ACT: begin m_open = 1'b1; m_row = er; t_act = cyc; end
        CMD_PRE: begin m_open = 1'b0; t_pre = cyc; end
        CMD_RD:  begin t_col = cyc; t_pre_ok = imax(t_pre_ok, cyc + T_RTP); end
        default: begin t_col = cyc; t_pre_ok = imax(t_pre_ok, cyc + T_WTP); end
      endcase
    end else if (ev) begin
      m_pend = 1'b1; m_pcmd = ec; m_prow = er;
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_req(input bit wr, input logic [RW-1:0] row);
    req_valid_i = 1'b1;
    req_wr_i    = wr;
    req_row_i   = row;
  endtask

  task automatic serve(input int budget);
    consumed = 1'b0;
    for (int i = 0; i < budget && !consumed; i++) tick();
    chk("serve_done", consumed, 1);
    req_valid_i = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  initial begin
    int c0, a5, t_w, rd_a, rd_b, rd_c, rd0;
    rst = 1'b1; req_valid_i = 1'b0; req_wr_i = 1'b0; req_row_i = '0;
    ref_req_i = 1'b0; cmd_ready_i = 1'b0;
    o_act = -1; o_pre = -1; o_rd = -1; o_wr = -1; o_gnt_rise = -1; o_act_row = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    prev_gnt = 1'b1;
    do_reset(1);

    // Reset state
    chk("rst_gnt", ref_gnt_o, 1);
    chk("rst_valid", cmd_valid_o, 0);
    chk("rst_cmd", cmd_o, CMD_ACT);
    chk("rst_row", cmd_row_o, 0);

    // Cold read
    cmd_ready_i = 1'b1;
    c0 = cyc;
    set_req(1'b0, 14'd5);
    serve(20);
    chk("cold_act_cycle", o_act, c0);
    chk("cold_act_row", o_act_row, 5);
    chk("cold_rd_gap", o_rd - o_act, T_RCD);

    // Hit burst
    set_req(1'b0, 14'd5); serve(10); rd_a = o_rd;
    set_req(1'b0, 14'd5); serve(10); rd_b = o_rd;
    set_req(1'b0, 14'd5); serve(10); rd_c = o_rd;
    chk("burst_gap1", rd_b - rd_a, T_CCD);
    chk("burst_gap2", rd_c - rd_b, T_CCD);

    // Miss after write (fresh ACT so tRAS is in play)
    do_reset(1);
    set_req(1'b1, 14'd5); serve(20);
    a5 = o_act; t_w = o_wr;
    set_req(1'b0, 14'd9); serve(40);
    chk("miss_pre", o_pre, imax(t_w + T_WTP, a5 + T_RAS));
    chk("miss_act", o_act, o_pre + T_RP);
    chk("miss_act_row", o_act_row, 9);
    chk("miss_rd", o_rd, o_act + T_RCD);

    // Backpressure on ACT
    do_reset(1);
    cmd_ready_i = 1'b0;
    set_req(1'b0, 14'd7);
    repeat (6) begin
      #1;
      chk("bp_valid", cmd_valid_o, 1);
      chk("bp_cmd", cmd_o, CMD_ACT);
      chk("bp_row", cmd_row_o, 7);
      tick();
    end
    cmd_ready_i = 1'b1;
    c0 = cyc;
    serve(20);
    chk("bp_act_cycle", o_act, c0);

    // Refresh with a pending hit read
    do_reset(1);
    set_req(1'b0, 14'd5); serve(20);
    a5 = o_act; rd0 = o_rd;
    set_req(1'b0, 14'd5);
    ref_req_i = 1'b1;
    repeat (30) tick();
    chk("ref_pre", o_pre, a5 + T_RAS);
    chk("ref_gnt_rise", o_gnt_rise, o_pre + T_RP);
    chk("ref_no_act", o_act, a5);
    chk("ref_no_rd", o_rd, rd0);
    ref_req_i = 1'b0;
    c0 = cyc;
    serve(20);
    chk("ref_reopen_act", o_act, c0);

    // Reset mid-tRCD
    do_reset(1);
    set_req(1'b0, 14'd3);
    c0 = cyc;
    tick();
    chk("rst_mid_act", o_act, c0);
    rd0 = o_rd;
    rst = 1'b1; req_valid_i = 1'b0;
    tick();
    rst = 1'b0;
    chk("rst_mid_gnt", ref_gnt_o, 1);
    repeat (6) tick();
    chk("rst_mid_no_rd", o_rd, rd0);

    // Randomized traffic
    do_reset(1);
    for (int i = 0; i < 3000; i++) begin
      cmd_ready_i = ($urandom_range(9) < 7);
      if ($urandom_range(99) < 3) ref_req_i = ~ref_req_i;
      if (!req_valid_i && $urandom_range(3) == 0)
        set_req(1'($urandom_range(1)), rows[$urandom_range(2)]);
      rst = ($urandom_range(499) == 0);
      tick();
      if (consumed) req_valid_i = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
